// File: rtl/izq_der_cmp_seq.sv
// Sequencer for the MSB-first iterative comparator cell. A single cell is
// time-shared over all N bit positions: one bit pair per clock is combined
// with the registered x (B greater) / y (A greater) flags.
module izq_der_cmp_seq #(
  parameter int N          = 8,
  parameter bit EARLY_EXIT = 1'b0,
  localparam int IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  a_in,
  input  logic [N-1:0]  b_in,
  output logic          ready,
  output logic          busy,
  output logic          done,
  output logic          a_gt_b,
  output logic          a_lt_b,
  output logic          a_eq_b,
  output logic [IW-1:0] bit_idx
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [IW-1:0] IDX_TOP = IW'(N - 1);

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  aOp_q, aOp_d;
  logic [N-1:0]  bOp_q, bOp_d;
  logic          x_q, x_d;
  logic          y_q, y_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          gt_q, gt_d;
  logic          lt_q, lt_d;
  logic          eq_q, eq_d;

  logic [N-1:0]  bitMask;
  logic          aBit;
  logic          bBit;
  logic          xNext;
  logic          yNext;
  logic          finish;

  // Cell function: pick the current bit pair and fold it into the flags.
  // A flag, once set, blocks the other one, so x and y are never both 1.
  always_comb begin
    bitMask = N'(1) << idx_q;
    aBit    = |(aOp_q & bitMask);
    bBit    = |(bOp_q & bitMask);
    xNext   = x_q | (~y_q & ~aBit & bBit);
    yNext   = y_q | (~x_q & aBit & ~bBit);
    finish  = (idx_q == '0) || (EARLY_EXIT && (xNext || yNext));
  end

  // Next-state logic; results are loaded on the RUN->DONE edge so they are
  // valid while done is high and then held until the next completion.
  always_comb begin
    state_d = state_q;
    aOp_d   = aOp_q;
    bOp_d   = bOp_q;
    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          aOp_d   = a_in;
          bOp_d   = b_in;
          x_d     = 1'b0;
          y_d     = 1'b0;
          idx_d   = IDX_TOP;
          state_d = RUN;
        end
      end
      RUN: begin
        x_d = xNext;
        y_d = yNext;
        if (finish) begin
          state_d = DONE;
          gt_d    = yNext;
          lt_d    = xNext;
          eq_d    = ~(xNext | yNext);
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any comparison in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      aOp_q   <= '0;
      bOp_q   <= '0;
      x_q     <= 1'b0;
      y_q     <= 1'b0;
      idx_q   <= IDX_TOP;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      aOp_q   <= aOp_d;
      bOp_q   <= bOp_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
    end
  end

  assign ready   = (state_q == IDLE) || (state_q == DONE);
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign a_gt_b  = gt_q;
  assign a_lt_b  = lt_q;
  assign a_eq_b  = eq_q;
  assign bit_idx = idx_q;

endmodule

// File: tb/tb_izq_der_cmp_seq.sv
// Directed bench for izq_der_cmp_seq: instance 0 is N=4 full-length,
// instance 1 is N=4 early-exit, instance 2 is N=1.
module tb_izq_der_cmp_seq;

  logic       clk;
  logic       rst_n;
  logic [2:0] start;
  logic [3:0] aIn;
  logic [3:0] bIn;
  logic [2:0] rdy, bsy, dn, gt, lt, eq;
  logic [1:0] idx0, idx1;
  logic       idx2;

  int checkCount;
  int failCount;

  izq_der_cmp_seq #(.N(4), .EARLY_EXIT(1'b0)) dutFull (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a_in(aIn), .b_in(bIn),
    .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]),
    .a_gt_b(gt[0]), .a_lt_b(lt[0]), .a_eq_b(eq[0]), .bit_idx(idx0)
  );

  izq_der_cmp_seq #(.N(4), .EARLY_EXIT(1'b1)) dutEarly (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a_in(aIn), .b_in(bIn),
    .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]),
    .a_gt_b(gt[1]), .a_lt_b(lt[1]), .a_eq_b(eq[1]), .bit_idx(idx1)
  );

  izq_der_cmp_seq #(.N(1), .EARLY_EXIT(1'b0)) dutOne (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .a_in(aIn[0:0]), .b_in(bIn[0:0]),
    .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]),
    .a_gt_b(gt[2]), .a_lt_b(lt[2]), .a_eq_b(eq[2]), .bit_idx(idx2)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    checkCount++;
    if (got != exp) begin
      failCount++;
      $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Start one comparison on instance sel and wait (bounded) for done.
  task automatic applyStimulus(input int sel, input logic [3:0] a, input logic [3:0] b,
                               input int expLat, input logic eg, input logic el,
                               input logic ee, input string tag);
    int lat;
    @(negedge clk);
    aIn = a;
    bIn = b;
    start[sel] = 1'b1;
    @(negedge clk);
    start[sel] = 1'b0;
    lat = 1;
    while (!dn[sel] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_lat"}, lat, expLat);
    checkOutput({tag, "_gt"}, int'(gt[sel]), int'(eg));
    checkOutput({tag, "_lt"}, int'(lt[sel]), int'(el));
    checkOutput({tag, "_eq"}, int'(eq[sel]), int'(ee));
  endtask

  initial begin
    int extra;
    logic a1, b1;
    checkCount = 0;
    failCount  = 0;
    rst_n = 1'b0;
    start = '0;
    aIn   = '0;
    bIn   = '0;
    repeat (2) @(negedge clk);

    // Reset state
    checkOutput("rst_ready", int'(rdy[0]), 1);
    checkOutput("rst_busy", int'(bsy[0]), 0);
    checkOutput("rst_done", int'(dn[0]), 0);
    checkOutput("rst_res", int'({gt[0], lt[0], eq[0]}), 0);
    checkOutput("rst_idx", int'(idx0), 3);
    rst_n = 1'b1;

    // Full-length run A=1010 B=1001: busy 4 cycles with idx 3..0, done on 5
    @(negedge clk);
    aIn = 4'b1010;
    bIn = 4'b1001;
    start[0] = 1'b1;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      start[0] = 1'b0;
      if (cyc <= 4) begin
        checkOutput($sformatf("t1_busy%0d", cyc), int'(bsy[0]), 1);
        checkOutput($sformatf("t1_idx%0d", cyc), int'(idx0), 4 - cyc);
        checkOutput($sformatf("t1_done%0d", cyc), int'(dn[0]), 0);
      end else if (cyc == 5) begin
        checkOutput("t1_done5", int'(dn[0]), 1);
        checkOutput("t1_ready5", int'(rdy[0]), 1);
        checkOutput("t1_res", int'({gt[0], lt[0], eq[0]}), 3'b100);
      end else begin
        checkOutput("t1_done6", int'(dn[0]), 0);
        checkOutput("t1_hold", int'({gt[0], lt[0], eq[0]}), 3'b100);
      end
    end

    // Early exit latencies versus full-length latency
    applyStimulus(1, 4'b0111, 4'b1000, 2, 1'b0, 1'b1, 1'b0, "ee_msb");
    applyStimulus(1, 4'b0110, 4'b0110, 5, 1'b0, 1'b0, 1'b1, "ee_eq");
    applyStimulus(1, 4'b1010, 4'b1001, 4, 1'b1, 1'b0, 1'b0, "ee_bit1");
    applyStimulus(0, 4'b0111, 4'b1000, 5, 1'b0, 1'b1, 1'b0, "full_msb");
    applyStimulus(0, 4'b1111, 4'b1111, 5, 1'b0, 1'b0, 1'b1, "full_eq");

    // start during RUN with other operands must be ignored
    @(negedge clk);
    aIn = 4'd3;
    bIn = 4'd9;
    start[0] = 1'b1;
    extra = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start[0] = (cyc == 2);
      if (cyc == 2) begin
        aIn = 4'd12;
        bIn = 4'd1;
      end
      if (cyc == 5) begin
        checkOutput("busy_done", int'(dn[0]), 1);
        checkOutput("busy_res", int'({gt[0], lt[0], eq[0]}), 3'b010);
      end else if (dn[0]) begin
        extra++;
      end
    end
    checkOutput("busy_noextra", extra, 0);

    // Reset asserted in RUN cycle 3
    @(negedge clk);
    aIn = 4'd14;
    bIn = 4'd2;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("mid_busy", int'(bsy[0]), 1);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_busy_rst", int'(bsy[0]), 0);
    checkOutput("mid_ready_rst", int'(rdy[0]), 1);
    checkOutput("mid_done_rst", int'(dn[0]), 0);
    checkOutput("mid_res_rst", int'({gt[0], lt[0], eq[0]}), 0);
    checkOutput("mid_idx_rst", int'(idx0), 3);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 4'd14, 4'd2, 5, 1'b1, 1'b0, 1'b0, "after_rst");

    // Back-to-back: start held through DONE, second operands taken there
    @(negedge clk);
    aIn = 4'd5;
    bIn = 4'd5;
    start[0] = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (cyc == 5) begin
        checkOutput("b2b_done1", int'(dn[0]), 1);
        checkOutput("b2b_res1", int'({gt[0], lt[0], eq[0]}), 3'b001);
        aIn = 4'd3;
        bIn = 4'd9;
      end else if (cyc == 6) begin
        start[0] = 1'b0;
        checkOutput("b2b_nogap", int'(bsy[0]), 1);
        checkOutput("b2b_idx", int'(idx0), 3);
      end else if (cyc == 10) begin
        checkOutput("b2b_done2", int'(dn[0]), 1);
        checkOutput("b2b_res2", int'({gt[0], lt[0], eq[0]}), 3'b010);
      end else begin
        checkOutput($sformatf("b2b_nodone%0d", cyc), int'(dn[0]), 0);
      end
    end
    @(negedge clk);

    // N=1 sweep of every bit pair
    for (int p = 0; p < 4; p++) begin
      a1 = p[1];
      b1 = p[0];
      applyStimulus(2, {3'b000, a1}, {3'b000, b1}, 2, a1 & ~b1, ~a1 & b1,
                    ~(a1 ^ b1), $sformatf("n1_%0d%0d", a1, b1));
      checkOutput($sformatf("n1_idx_%0d", p), int'(idx2), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
